// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core.
// Supports stall hold, flush-to-bubble, exception merge, saturating Tnew countdown and a bubble counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W            = 64,
    parameter int unsigned TNEW_W            = 2,
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned TNEW_DEC_ON_STALL = 0,
    parameter int unsigned FLUSH_KEEP_PC     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [31:0]       pc_in,
    input  logic [4:0]        wa_in,
    input  logic [TNEW_W-1:0] tnew_in,
    input  logic [4:0]        exc_in,
    input  logic [4:0]        exc_local,
    input  logic              bd_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [31:0]       pc_out,
    output logic [4:0]        wa_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic [4:0]        exc_out,
    output logic              bd_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [31:0]       pc_nxt;
    logic [4:0]        wa_nxt;
    logic [TNEW_W-1:0] tnew_nxt;
    logic [4:0]        exc_nxt;
    logic              bd_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [4:0]        exc_m;
    logic              bubble;

    // Next-state selection: flush > stall > load; an empty upstream slot loads as a bubble.
    always_comb begin
        valid_nxt = valid_out;
        data_nxt  = data_out;
        pc_nxt    = pc_out;
        wa_nxt    = wa_out;
        tnew_nxt  = tnew_out;
        exc_nxt   = exc_out;
        bd_nxt    = bd_out;
        cnt_nxt   = bubble_cnt;
        exc_m     = (exc_in != 5'd0) ? exc_in : exc_local;
        bubble    = flush || (!stall && !valid_in);

        if (bubble) begin
            valid_nxt = 1'b0;
            data_nxt  = '0;
            wa_nxt    = 5'd0;
            tnew_nxt  = '0;
            exc_nxt   = 5'd0;
            pc_nxt    = (FLUSH_KEEP_PC != 0) ? pc_in : 32'd0;
            bd_nxt    = (FLUSH_KEEP_PC != 0) ? bd_in : 1'b0;
            cnt_nxt   = bubble_cnt + CNT_W'(1);
        end else if (stall) begin
            if (TNEW_DEC_ON_STALL != 0 && tnew_out != '0) begin
                tnew_nxt = tnew_out - TNEW_W'(1);
            end
        end else begin
            valid_nxt = 1'b1;
            data_nxt  = data_in;
            pc_nxt    = pc_in;
            bd_nxt    = bd_in;
            exc_nxt   = exc_m;
            // A faulting instruction never writes a GPR and never produces a pending result.
            wa_nxt    = (exc_m != 5'd0) ? 5'd0 : wa_in;
            tnew_nxt  = (exc_m != 5'd0 || tnew_in == '0) ? '0 : tnew_in - TNEW_W'(1);
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out  <= 1'b0;
            data_out   <= '0;
            pc_out     <= 32'd0;
            wa_out     <= 5'd0;
            tnew_out   <= '0;
            exc_out    <= 5'd0;
            bd_out     <= 1'b0;
            bubble_cnt <= '0;
        end else begin
            valid_out  <= valid_nxt;
            data_out   <= data_nxt;
            pc_out     <= pc_nxt;
            wa_out     <= wa_nxt;
            tnew_out   <= tnew_nxt;
            exc_out    <= exc_nxt;
            bd_out     <= bd_nxt;
            bubble_cnt <= cnt_nxt;
        end
    end

endmodule
